// File: rtl/shift_exec_stage.sv
// shift_exec_stage: handshaked, registered shift execution stage.
//
// Flow: request register (S1) -> shift unit -> 2-entry in-order result FIFO.
// Sustains one result per cycle while downstream keeps out_ready high.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_ready depends on registered state only
//   in_op               00 SLL, 01 SRL, 11 SRA, 10 ROR (optional) / illegal
//   in_data, in_shamt   operand and unsigned shift amount
//   in_tag              opaque tag echoed with the result
//   out_valid/out_ready downstream handshake on the FIFO head
//   out_data, out_tag   head result and its tag
//   out_zero            head result is zero
//   out_illegal         head request used an unsupported op
//
// Build option: define SHIFT_EXEC_ROTATE_EN to make op 10 a rotate-right;
// otherwise op 10 yields data 0 with out_zero = out_illegal = 1.

module shift_exec_stage #(
    parameter int unsigned N     = 32,
    parameter int unsigned TAG_W = 4,
    localparam int unsigned SW   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [N-1:0]     in_data,
    input  logic [SW-1:0]    in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_illegal
);

    // S1 request register
    logic             s1_valid_q, s1_valid_d;
    logic [1:0]       s1_op_q, s1_op_d;
    logic [N-1:0]     s1_data_q, s1_data_d;
    logic [SW-1:0]    s1_shamt_q, s1_shamt_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    // Result FIFO
    logic [N-1:0]     fifo_data_q [2];
    logic [N-1:0]     fifo_data_d [2];
    logic [TAG_W-1:0] fifo_tag_q  [2];
    logic [TAG_W-1:0] fifo_tag_d  [2];
    logic [1:0]       fifo_zero_q, fifo_zero_d;
    logic [1:0]       fifo_ill_q, fifo_ill_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    logic             accept, push, pop;
    logic [N-1:0]     res_data;
    logic             res_ill;

`ifdef SHIFT_EXEC_ROTATE_EN
    logic [SW:0]      rot_amt;
    assign rot_amt = (SW + 1)'(N) - (SW + 1)'(s1_shamt_q);
`endif

    assign in_ready  = !s1_valid_q || (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign accept    = in_valid && in_ready;
    // A pop frees a slot in the same edge, so a full FIFO still takes S1.
    assign push      = s1_valid_q && ((count_q != 2'd2) || pop);

    assign out_data    = fifo_data_q[rd_ptr_q];
    assign out_tag     = fifo_tag_q[rd_ptr_q];
    assign out_zero    = fifo_zero_q[rd_ptr_q];
    assign out_illegal = fifo_ill_q[rd_ptr_q];

    // Shift unit
    always_comb begin
        res_data = '0;
        res_ill  = 1'b0;
        case (s1_op_q)
            2'b00: res_data = s1_data_q << s1_shamt_q;
            2'b01: res_data = s1_data_q >> s1_shamt_q;
            2'b11: res_data = N'($signed(s1_data_q) >>> s1_shamt_q);
            default: begin
`ifdef SHIFT_EXEC_ROTATE_EN
                // Guard shamt 0: a shift by the full width would not be a no-op.
                if (s1_shamt_q == '0) begin
                    res_data = s1_data_q;
                end else begin
                    res_data = (s1_data_q >> s1_shamt_q) | (s1_data_q << rot_amt);
                end
`else
                res_ill = 1'b1;
`endif
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_data_d   = s1_data_q;
        s1_shamt_d  = s1_shamt_q;
        s1_tag_d    = s1_tag_q;
        fifo_data_d = fifo_data_q;
        fifo_tag_d  = fifo_tag_q;
        fifo_zero_d = fifo_zero_q;
        fifo_ill_d  = fifo_ill_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = in_op;
            s1_data_d  = in_data;
            s1_shamt_d = in_shamt;
            s1_tag_d   = in_tag;
        end else if (push) begin
            s1_valid_d = 1'b0;
        end

        if (push) begin
            fifo_data_d[wr_ptr_q] = res_data;
            fifo_tag_d[wr_ptr_q]  = s1_tag_q;
            fifo_zero_d[wr_ptr_q] = (res_data == '0);
            fifo_ill_d[wr_ptr_q]  = res_ill;
            wr_ptr_d              = !wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_data_q   <= '0;
            s1_shamt_q  <= '0;
            s1_tag_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_tag_q[i]  <= '0;
            end
            fifo_zero_q <= '0;
            fifo_ill_q  <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_data_q   <= s1_data_d;
            s1_shamt_q  <= s1_shamt_d;
            s1_tag_q    <= s1_tag_d;
            fifo_data_q <= fifo_data_d;
            fifo_tag_q  <= fifo_tag_d;
            fifo_zero_q <= fifo_zero_d;
            fifo_ill_q  <= fifo_ill_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Handshaked, registered execution stage that owns the datapath's shift operations (SLL, SRL, SRA) and queues results for the writeback side.
- Sits between operand issue (upstream, valid/ready) and writeback (downstream, valid/ready).
- Internal flow: one request register (S1), then shift computation, then a 2-entry in-order result FIFO.
- Sustains one result per cycle when downstream does not stall.

Parameters:
- N, 32, data width; the block is verified only at 32.
- TAG_W, 4, width of the opaque tag carried alongside each request.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  request present.
- in_ready  output  1  stage can accept a request this cycle.
- in_op  input  2  00 SLL, 01 SRL, 11 SRA, 10 reserved/ROR.
- in_data  input  N  operand.
- in_shamt  input  $clog2(N)  shift amount, unsigned 0..N-1.
- in_tag  input  TAG_W  opaque tag, returned unchanged.
- out_valid  output  1  result at FIFO head.
- out_ready  input  1  downstream consumes the head this cycle.
- out_data  output  N  shift result.
- out_tag  output  TAG_W  tag of the result.
- out_zero  output  1  out_data == 0.
- out_illegal  output  1  request used an unsupported op.

Behaviour:
- Accept: a request transfers when in_valid && in_ready at a rising edge E. S1 captures op, data, shamt and tag, and sets s1_valid.
- in_ready = !s1_valid || (fifo_count != 2). It is decoded from registered state only; there is no combinational path from out_ready or in_valid.
- S1 advance: when s1_valid && (fifo_count < 2 || pop), the computed result is written to the FIFO tail at the edge.
  - pop = out_valid && out_ready.
  - Push and pop in the same edge keep fifo_count unchanged.
- Latency: a request accepted at edge E appears on out_* immediately after edge E+1, provided the FIFO had space.
- Throughput: with out_ready held at 1, one result per cycle, no bubbles.
- FIFO:
  - 2 entries, strict in-order.
  - out_valid = (fifo_count != 0).
  - out_* reflect the head entry and are held stable while out_valid && !out_ready.
  - Head data does not change until popped.
- Full stall: with fifo_count == 2 and s1_valid, in_ready = 0.
  - If a pop occurs that edge, S1 still advances into the freed slot.
  - in_ready rises the following cycle.
  - Maximum buffered requests: 3 (2 in the FIFO plus S1).
- Arithmetic, all results truncated to N bits:
  - SLL: data << shamt, zero fill.
  - SRL: data >> shamt, zero fill.
  - SRA: data >> shamt, filled with data[N-1].
  - shamt = 0 passes data unchanged for every op.
  - SRA of a negative value with shamt N-1 gives all ones.
- out_zero and out_illegal are computed at S1 advance and stored per FIFO entry.
- Reset (asserted at any time, including mid-transfer):
  - s1_valid = 0, fifo_count = 0, pointers = 0.
  - All stored data, tags and flags cleared to 0.
  - Outputs during and after reset: out_valid 0, out_data 0, out_tag 0, out_zero 0, out_illegal 0, in_ready 1.
  - In-flight requests are discarded and never emitted.
- Inputs are ignored whenever in_valid = 0. in_op, in_data, in_shamt and in_tag may change freely when not transferring.

Optional Feature:
- Macro: SHIFT_EXEC_ROTATE_EN.
- Defined: op 10 performs rotate-right. out_data = (data >> shamt) | (data << (N - shamt)), with shamt 0 passing data unchanged. out_illegal = 0.
- Undefined: op 10 is illegal. out_data = 0, out_zero = 1, out_illegal = 1. The entry still flows through S1 and the FIFO in order with its tag.
- Ops 00, 01 and 11 are identical in both builds.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with 3 requests buffered -> out_valid drops immediately, in_ready = 1, out_data = 0; after release, no stale results emerge.
- Arithmetic with out_ready = 1 -> each result 1 cycle after its accept edge, tag echoed:
  - SRA 0x8000_0000 shamt 4 -> 0xF800_0000.
  - SRA 0xFFFF_FFF0 shamt 31 -> 0xFFFF_FFFF.
  - SLL 0x0000_0001 shamt 31 -> 0x8000_0000.
  - SRL 0x8000_0000 shamt 31 -> 0x0000_0001.
  - SRL 0x1234_5678 shamt 0 -> 0x1234_5678.
  - SLL 0x0000_0002 shamt 31 -> 0, out_zero = 1.
- Backpressure: out_ready = 0, offer tags 1..4 back-to-back -> tags 1-3 accepted, in_ready = 0 with tag 4 pending, out_data for tag 1 held stable. Raise out_ready -> tags 1, 2, 3, 4 emitted in order, no loss or duplication.
- Streaming: in_valid = out_ready = 1 for 16 consecutive SRL requests, shamt = i -> 16 results on 16 consecutive cycles, in_ready never drops.
- Op 10, data 0x0000_00F1, shamt 4:
  - With SHIFT_EXEC_ROTATE_EN -> out_data 0x1000_000F, out_illegal 0.
  - Without -> out_data 0, out_zero 1, out_illegal 1, ordering with neighbouring SLL/SRA requests preserved.
